// File: rtl/seg7_scan_if.sv
// rtl/seg7_scan_if.sv - bus between user datapath and the 7-segment scan driver
// Purpose: groups the load-side inputs and the display/status outputs.
// Signals:
//   data[4*NUM_DIGITS-1:0]  packed nibbles, data[3:0] = digit 0 (rightmost)
//   dp[NUM_DIGITS-1:0]      decimal point per digit, 1 = lit
//   mode                    0 = hex glyphs, 1 = BCD (nibble > 9 shows dash)
//   load                    single-cycle strobe capturing data/dp/mode
//   seg[7:0]                segments, active-low, seg[7] = dp, seg[6:0] = g..a
//   an[NUM_DIGITS-1:0]      digit enables, active-low
//   pending                 shadow holds data not yet shown
//   frame                   one-cycle pulse at the start of each frame
// Modports: master = datapath side, slave = driver side.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    mode;
  logic                    load;
  logic [7:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    pending;
  logic                    frame;

  modport master (
    output data, dp, mode, load,
    input  seg, an, pending, frame
  );

  modport slave (
    input  data, dp, mode, load,
    output seg, an, pending, frame
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed common-anode 7-segment scan driver
// Purpose: latches nibbles/decimal points/mode into a shadow on load, copies the
//   shadow to the display registers only at frame wrap (no tearing), and scans
//   one digit per SCAN_DIV cycles with registered active-low seg/an.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    seg7_scan_if.slave (data, dp, mode, load in; seg, an, pending, frame out)
// Parameters: NUM_DIGITS (1..8), SCAN_DIV (>= 2)
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zeros.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000
) (
  input  logic          clk,
  input  logic          rst_n,
  seg7_scan_if.slave    bus
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] AN_ONE = 1;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] sh_data, dsp_data;
  logic [NUM_DIGITS-1:0]   sh_dp, dsp_dp;
  logic                    sh_mode, dsp_mode;
  logic                    pending_q;
  logic                    wrap_q, frame_q;
  logic [7:0]              seg_q, seg_nxt;
  logic [NUM_DIGITS-1:0]   an_q;
  logic                    tick, wrap;
  logic [3:0]              nib;

  assign tick = (cnt == CW'(SCAN_DIV - 1));
  assign wrap = tick && (idx == IW'(NUM_DIGITS - 1));

  // Active-low g..a patterns; bit 7 of the table is the unlit DP and is dropped.
  function automatic logic [6:0] glyph(input logic [3:0] n, input logic bcd);
    logic [7:0] g;
    case (n)
      4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
      4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
      4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
      4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
    endcase
    if (bcd && (n > 4'd9)) g = 8'hBF;
    return g[6:0];
  endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank;
  logic                  zero_above;

  // Walk from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (dsp_data[4*i +: 4] == 4'h0);
      blank[i]   = zero_above && !dsp_dp[i];
    end
  end
`endif

  always_comb begin
    nib     = dsp_data[4*int'(idx) +: 4];
    seg_nxt = {~dsp_dp[idx], glyph(nib, dsp_mode)};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (blank[idx]) seg_nxt = 8'hFF;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      sh_data   <= '0;
      sh_dp     <= '0;
      sh_mode   <= 1'b0;
      dsp_data  <= '0;
      dsp_dp    <= '0;
      dsp_mode  <= 1'b0;
      pending_q <= 1'b0;
      wrap_q    <= 1'b0;
      frame_q   <= 1'b0;
      seg_q     <= 8'hFF;
      an_q      <= '1;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (wrap)      idx <= '0;
      else if (tick) idx <= idx + 1'b1;

      // frame is delayed one extra cycle so it lines up with seg/an, which
      // lag idx by one register stage.
      wrap_q  <= wrap;
      frame_q <= wrap_q;

      if (bus.load) begin
        sh_data <= bus.data;
        sh_dp   <= bus.dp;
        sh_mode <= bus.mode;
      end

      // A load on the wrap cycle bypasses the shadow so it shows this frame.
      if (bus.load && wrap) begin
        dsp_data  <= bus.data;
        dsp_dp    <= bus.dp;
        dsp_mode  <= bus.mode;
        pending_q <= 1'b0;
      end else if (bus.load) begin
        pending_q <= 1'b1;
      end else if (wrap && pending_q) begin
        dsp_data  <= sh_data;
        dsp_dp    <= sh_dp;
        dsp_mode  <= sh_mode;
        pending_q <= 1'b0;
      end

      seg_q <= seg_nxt;
      an_q  <= ~(AN_ONE << idx);
    end
  end

  assign bus.seg     = seg_q;
  assign bus.an      = an_q;
  assign bus.pending = pending_q;
  assign bus.frame   = frame_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;
  localparam int N = 4;
  localparam int S = 4;
  localparam int F = N * S;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time-indexed by edges since reset release.
  int          k;
  logic [15:0] m_data, m_sdata;
  logic [3:0]  m_dp, m_sdp;
  logic        m_mode, m_smode, m_pend;
  logic [7:0]  gl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        mode;
    logic [31:0] exp;  // {d3, d2, d1, d0}
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_seg(input int d);
    logic [3:0] nib;
    logic [7:0] g;
    nib = 4'((m_data >> (4 * d)) & 16'hF);
    g   = (m_mode && nib > 4'd9) ? 8'hBF : gl[nib];
    g[7] = ~m_dp[d];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (d > 0 && (m_data >> (4 * d)) == 16'h0 && !m_dp[d]) g = 8'hFF;
`endif
    return g;
  endfunction

  task automatic model_reset();
    k = 0;
    m_data = '0; m_dp = '0; m_mode = 1'b0;
    m_sdata = '0; m_sdp = '0; m_smode = 1'b0; m_pend = 1'b0;
  endtask

  // One clock: predict, advance model, clock, then compare all outputs.
  task automatic step();
    int d;
    logic [7:0] es;
    logic [3:0] ea;
    logic ef, wr;
    d  = (k / S) % N;
    es = ref_seg(d);
    ea = ~(4'b0001 << d);
    ef = (k % F == 0) && (k > 0);
    wr = ((k + 1) % F) == 0;
    if (bus.load && wr) begin
      m_data = bus.data; m_dp = bus.dp; m_mode = bus.mode; m_pend = 1'b0;
      m_sdata = bus.data; m_sdp = bus.dp; m_smode = bus.mode;
    end else if (bus.load) begin
      m_sdata = bus.data; m_sdp = bus.dp; m_smode = bus.mode; m_pend = 1'b1;
    end else if (wr && m_pend) begin
      m_data = m_sdata; m_dp = m_sdp; m_mode = m_smode; m_pend = 1'b0;
    end
    k++;
    @(posedge clk);
    #1;
    chk("seg", 32'(bus.seg), 32'(es));
    chk("an", 32'(bus.an), 32'(ea));
    chk("pending", 32'(bus.pending), 32'(m_pend));
    chk("frame", 32'(bus.frame), 32'(ef));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_seg", 32'(bus.seg), 32'hFF);
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_pending", 32'(bus.pending), 32'h0);
    chk("rst_frame", 32'(bus.frame), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_seg", 32'(bus.seg), 32'hFF);
    rst_n = 1'b1;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic m);
    bus.data = d; bus.dp = p; bus.mode = m; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  task automatic step_until_phase(input int ph);
    int guard = 0;
    while ((k % F) != ph && guard < 2 * F) begin step(); guard++; end
  endtask

  // Waits for frame, then gathers one full frame of seg values per digit.
  task automatic collect(output logic [31:0] got, output int n_f9);
    int guard = 0;
    got = '1;
    n_f9 = 0;
    while (bus.frame !== 1'b1 && guard < 3 * F) begin step(); guard++; end
    chk("frame_seen", 32'(bus.frame), 32'h1);
    for (int j = 0; j < F; j++) begin
      for (int d = 0; d < N; d++)
        if (bus.an == ~(4'b0001 << d)) got[8*d +: 8] = bus.seg;
      if (bus.seg == 8'hF9) n_f9++;
      step();
    end
  endtask

  initial begin
    logic [31:0] got;
    int n_f9;

    bus.data = '0; bus.dp = '0; bus.mode = 1'b0; bus.load = 1'b0;
    vecs[0] = '{16'h3A91, 4'b0010, 1'b0, 32'hB0_88_10_F9};
    vecs[1] = '{16'h3A91, 4'b0010, 1'b1, 32'hB0_BF_10_F9};
    vecs[2] = '{16'h2222, 4'b0000, 1'b0, 32'hA4_A4_A4_A4};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    vecs[3] = '{16'h0050, 4'b0000, 1'b0, 32'hFF_FF_92_C0};
    vecs[4] = '{16'h0000, 4'b0000, 1'b0, 32'hFF_FF_FF_C0};
`else
    vecs[3] = '{16'h0050, 4'b0000, 1'b0, 32'hC0_C0_92_C0};
    vecs[4] = '{16'h0000, 4'b0000, 1'b0, 32'hC0_C0_C0_C0};
`endif
    vecs[5] = '{16'hBCDE, 4'b1001, 1'b0, 32'h03_C6_A1_06};

    #2;
    do_reset();
    step();
    chk("first_an", 32'(bus.an), 32'hE);
    chk("first_seg", 32'(bus.seg), 32'hC0);
    repeat (2 * F + 3) step();

    // Table vectors, loaded mid-frame.
    foreach (vecs[i]) begin
      step_until_phase(5);
      do_load(vecs[i].data, vecs[i].dp, vecs[i].mode);
      chk("pending_after_load", 32'(bus.pending), 32'h1);
      collect(got, n_f9);
      chk($sformatf("vec%0d", i), got, vecs[i].exp);
    end

    // Two loads before one wrap: latest wins, first never shows.
    step_until_phase(2);
    do_load(16'h1111, 4'b0000, 1'b0);
    do_load(16'h2222, 4'b0000, 1'b0);
    collect(got, n_f9);
    chk("latest_wins", got, 32'hA4A4A4A4);
    chk("no_1111_glyph", 32'(n_f9), 32'h0);

    // Load on the wrap cycle: shown in the new frame, pending never set.
    step_until_phase(F - 1);
    do_load(16'h5678, 4'b0000, 1'b0);
    chk("wrap_load_pending", 32'(bus.pending), 32'h0);
    step();
    chk("wrap_load_frame", 32'(bus.frame), 32'h1);
    chk("wrap_load_seg", 32'(bus.seg), 32'h80);

    // Asynchronous reset mid-frame with pending set.
    step_until_phase(6);
    do_load(16'h4444, 4'b0000, 1'b0);
    step();
    #2;
    do_reset();
    step();
    chk("post_rst_seg", 32'(bus.seg), 32'hC0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.load = ($urandom_range(0, 7) == 0);
      bus.data = 16'($urandom);
      bus.dp   = 4'($urandom);
      bus.mode = 1'($urandom);
      step();
    end
    bus.load = 1'b0;
    repeat (F) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed, parametrised 7-segment display driver for the board's common-anode digit bank. It latches a packed nibble word plus decimal points through a load strobe and applies the update only at frame boundaries, so the display never tears mid-frame. It time-multiplexes one digit per scan slot with registered active-low SEG/AN outputs. It sits between the user datapath (switch/counter logic) and the board pins, replacing per-digit static decoders.

## Interface
- NUM_DIGITS, 8, number of digits scanned (1..8)
- SCAN_DIV, 100000, clock cycles each digit is lit (≥2)
- CLK  input  1  system clock, all state on rising edge
- RST_N  input  1  reset, asynchronous, active-low
- DATA  input  4*NUM_DIGITS  packed nibbles; DATA[3:0] = digit 0 (rightmost)
- DP  input  NUM_DIGITS  decimal point per digit, 1 = lit
- MODE  input  1  0 = hex glyphs, 1 = BCD (nibble >9 shows dash)
- LOAD  input  1  single-cycle strobe capturing DATA/DP/MODE into shadow
- SEG  output  8  segments, active-low, SEG[7] = DP, SEG[6:0] = g..a
- AN  output  NUM_DIGITS  digit enables, active-low, exactly one low after reset
- PENDING  output  1  shadow holds data not yet shown
- FRAME  output  1  one-cycle pulse when the digit index wraps to 0

## Operation
- State: divider cnt (0..SCAN_DIV-1), digit index idx (0..NUM_DIGITS-1), shadow regs, display regs, PENDING flag.
- cnt increments every cycle; at SCAN_DIV-1 it clears and idx advances; idx wraps NUM_DIGITS-1 -> 0.
- On wrap: FRAME pulses; if PENDING, display regs <= shadow, PENDING <= 0.
- LOAD: shadow <= {DATA, DP, MODE}, PENDING <= 1. LOAD while PENDING overwrites the shadow (latest wins).
- LOAD in the same cycle as wrap: display regs take the LOAD inputs directly and PENDING ends 0.
- Glyphs (SEG[6:0], active-low): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E (bit 7 shown set). In BCD mode, nibble 10..15 shows dash 8'hBF.
- SEG[7] = ~DP[idx] of the display regs.
- AN = ~(1 << idx); SEG/AN are registered from the idx of the previous cycle, so they lag idx by one cycle.

## Timing
- Reset (async assert, any time, including mid-frame or with PENDING set): cnt=0, idx=0, display regs=0, shadow=0, PENDING=0, FRAME=0, SEG=8'hFF, AN=all ones.
- First clock after RST_N release: AN=~1, SEG=glyph of digit 0 (8'hC0 with display regs 0).
- Each digit is low on AN for exactly SCAN_DIV cycles; the frame period is NUM_DIGITS*SCAN_DIV cycles.
- LOAD -> PENDING high on the next edge; the visible update lands at the next wrap, which occurs 1..NUM_DIGITS*SCAN_DIV cycles later.
- FRAME is high for exactly the cycle after the wrap edge (registered) and coincides with the first AN=~1 cycle of the new frame.
- NUM_DIGITS=1: idx stays 0, and a wrap occurs every SCAN_DIV cycles.

## Configuration
- SEG7_LEADING_ZERO_BLANK_EN defined: a digit whose nibble and all more-significant nibbles are 0, with its own DP=0, is blanked. A blanked digit has SEG=8'hFF while AN still scans. Digit 0 is never blanked.
- Undefined: all digits are always shown, and zeros display as 8'hC0.

## Test plan
- Reset, NUM_DIGITS=4, SCAN_DIV=4 -> AN cycles E,D,B,7, each for 4 cycles; SEG=C0 for every digit; FRAME pulses every 16 cycles.
- LOAD DATA=16'h3A91, DP=4'b0010, MODE=0 mid-frame -> PENDING=1 until the wrap; next frame SEG = F9 (d0), 10 (d1, DP lit), 88 (d2), B0 (d3).
- Same DATA with MODE=1 -> digit 2 shows BF; other digits unchanged.
- Two LOADs before the wrap (16'h1111 then 16'h2222) -> only 2222 is displayed (A4 on all digits); the 1111 pattern never appears.
- LOAD asserted on the wrap cycle -> new data visible in the same frame, PENDING stays 0; RST_N low mid-frame with PENDING=1 -> SEG=FF, AN=F, PENDING=0 immediately.
- With SEG7_LEADING_ZERO_BLANK_EN, DATA=16'h0050 -> digits 3 and 2 show FF, digit 1 shows 92, digit 0 shows C0; DATA=16'h0000 -> only digit 0 shows C0.
